gmii_tx_reconciliation: RTL



---
 rtl/gmii_tx_reconciliation.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_reconciliation.sv
// Purpose: GMII transmit reconciliation. Adds preamble and SFD, forwards MAC bytes with
//          their error flags, appends carrier extension up to the slot size, and holds the IFG.
// Latency: 1 cycle from MAC byte acceptance to txd. Outputs are registered and there are no bubbles.
// Backpressure: mac_ready is high only in SFD/DATA until the last byte is accepted. If the MAC
//               starves while mac_ready is high, the frame is aborted with an error byte.
// Ports:
//   tx_clk, reset                         : clock and synchronous active-high reset
//   mac_data/mac_valid/mac_last/mac_error : MAC byte stream and per-byte flags
//   ext_en                                : carrier extension enable, latched at frame start
//   mac_ready                             : byte accepted when mac_ready && mac_valid
//   txd/tx_en/tx_er                       : GMII transmit signals (registered)
//   busy, underrun                        : frame in progress; one-cycle starvation pulse
module gmii_tx_reconciliation #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12,
  parameter int SLOT_BYTES     = 512,
  parameter int CNT_W          = 10
) (
  input  logic       tx_clk,
  input  logic       reset,
  input  logic [7:0] mac_data,
  input  logic       mac_valid,
  input  logic       mac_last,
  input  logic       mac_error,
  input  logic       ext_en,
  output logic       mac_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRE    = 3'd1;
  localparam logic [2:0] ST_SFD    = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_EXTEND = 3'd4;
  localparam logic [2:0] ST_IFG    = 3'd5;

  localparam logic [7:0] PRE_BYTE     = 8'h55;
  localparam logic [7:0] SFD_BYTE     = 8'hD5;
  localparam logic [7:0] EXT_BYTE     = 8'h0F;
  localparam logic [7:0] EXT_ERR_BYTE = 8'h1F;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BYTES - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);
  localparam logic [CNT_W-1:0] SLOT     = CNT_W'(SLOT_BYTES);

  // state names what is on the wire in the current cycle; outputs are loaded
  // at each edge with the value belonging to the next state.
  logic [2:0]       state;
  // Shared counter: preamble index, data byte count (later the extension
  // position), and IFG index.
  logic [CNT_W-1:0] cnt;
  logic             ext_lat;    // ext_en captured at frame start
  logic             data_done;  // last byte (or underrun marker) already accepted
  logic             underran;   // frame aborted, never extend

  assign mac_ready = (state == ST_SFD) || ((state == ST_DATA) && !data_done);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ext_lat   <= 1'b0;
      data_done <= 1'b0;
      underran  <= 1'b0;
      txd       <= 8'h00;
      tx_en     <= 1'b0;
      tx_er     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      // Wire idle unless a state below drives something else.
      txd      <= 8'h00;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mac_valid) begin
            state     <= ST_PRE;
            cnt       <= '0;
            ext_lat   <= ext_en;
            data_done <= 1'b0;
            underran  <= 1'b0;
            txd       <= PRE_BYTE;
            tx_en     <= 1'b1;
          end
        end
        ST_PRE: begin
          tx_en <= 1'b1;
          if (cnt == PRE_LAST) begin
            state <= ST_SFD;
            cnt   <= '0;
            txd   <= SFD_BYTE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            txd <= PRE_BYTE;
          end
        end
        ST_SFD, ST_DATA: begin
          if (!data_done) begin
            // mac_ready is high here, so a missing byte is an underrun.
            state <= ST_DATA;
            tx_en <= 1'b1;
            if (mac_valid) begin
              txd       <= mac_data;
              tx_er     <= mac_error;
              data_done <= mac_last;
              if (cnt != SLOT) cnt <= cnt + CNT_W'(1);
            end else begin
              tx_er     <= 1'b1;
              underrun  <= 1'b1;
              data_done <= 1'b1;
              underran  <= 1'b1;
            end
          end else if (!underran && ext_lat && (cnt < SLOT)) begin
            // cnt walks from the byte count up to SLOT: SLOT-count extend cycles.
            state <= ST_EXTEND;
            cnt   <= cnt + CNT_W'(1);
            tx_er <= 1'b1;
            txd   <= mac_error ? EXT_ERR_BYTE : EXT_BYTE;
          end else begin
            state <= ST_IFG;
            cnt   <= '0;
          end
        end
        ST_EXTEND: begin
          if (cnt == SLOT) begin
            state <= ST_IFG;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            tx_er <= 1'b1;
            txd   <= mac_error ? EXT_ERR_BYTE : EXT_BYTE;
          end
        end
        ST_IFG: begin
          // The final IFG edge acts as the IDLE sampling edge. A waiting
          // frame therefore sees exactly IFG_BYTES idle cycles.
          if (cnt == IFG_LAST) begin
            if (mac_valid) begin
              state     <= ST_PRE;
              cnt       <= '0;
              ext_lat   <= ext_en;
              data_done <= 1'b0;
              underran  <= 1'b0;
              txd       <= PRE_BYTE;
              tx_en     <= 1'b1;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
